mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store initiator that sits between the core's memory stage and a single-port M10K data RAM. It accepts one RISC-V load or store per handshake and drives the RAM's word-address, write-data and write-enable bus. It sign- or zero-extends load data. The RAM commits whole words only, so sub-word stores are performed as read-modify-write.

## Interface
- `SIZE`, 512, RAM depth in 32-bit words; address aliasing modulo `SIZE*4` bytes.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  `state==IDLE && !reset`; a transfer occurs when `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data in low bits.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  valid with `resp_valid`; misaligned or illegal request.
- `mem_addr`  out  32  word index, `req_addr[31:2]` zero-extended.
- `mem_wdata`  out  32  RAM write data.
- `mem_we`  out  4  byte write enables.
- `mem_rdata`  in  32  RAM read data; valid the cycle after `mem_addr` is presented with `mem_we==0`.

## Operation
- All outputs except `req_ready` are registered. Reset values:
  - `resp_valid`, `resp_err`, `mem_we`: 0.
  - `resp_rdata`, `mem_addr`, `mem_wdata`: 0.
  - state IDLE.
- FSM states: IDLE, RD, DATA, WR.
- **IDLE:** on accept, latch the request and classify it:
  - Error if funct3 ∈ {011, 110, 111}, or store with funct3 ∈ {100, 101}, or H/HU with `addr[0]=1`, or W with `addr[1:0]!=0`.
  - Error → stay IDLE; next cycle `resp_valid=1`, `resp_err=1`, no RAM access.
  - Load or sub-word store → RD.
  - SW → WR.
- **RD:** `mem_addr` = word index, `mem_we=0` → DATA.
- **DATA:** `mem_rdata` is valid.
  - Load: byte lane `addr[1:0]`, little-endian. B/H sign-extend; BU/HU zero-extend. Result to `resp_rdata`; → IDLE with `resp_valid` pulse.
  - Sub-word store: merge `req_wdata[7:0]` or `[15:0]` into the addressed lane(s) of `mem_rdata`, register into `mem_wdata` → WR.
- **WR:** `mem_we=4'hF`, one cycle; → IDLE with `resp_valid` pulse, `resp_err=0`.
- `mem_we` is 0 in every state except WR.
- `req_ready` is 1 during the `resp_valid` cycle, so a new request may be accepted in that cycle.
- Out-of-range addresses are not errors; the RAM truncates the index, so accesses wrap.
- Reset mid-operation: transaction abandoned, no `resp_valid`.
  - A WR cycle coinciding with the reset edge still commits, because the RAM is not reset.
  - Reset in RD or DATA produces no write.

## Timing
- Accept edge = cycle 0.
- Error: `resp_valid` in cycle 1.
- SW: WR in cycle 1, `resp_valid` in cycle 2.
- Load: RD in cycle 1, DATA in cycle 2, `resp_valid` in cycle 3.
- SB/SH (RMW): RD in cycle 1, DATA in cycle 2, WR in cycle 3, `resp_valid` in cycle 4.
- Throughput: one request per latency interval; no outstanding-request overlap.
- Read-during-write is never issued: RD and WR are distinct cycles.

## Configuration
- `MEM_LSU_NATIVE_BE_EN` defined:
  - The RAM honours per-byte enables.
  - SB/SH go IDLE → WR directly, with `mem_we` = lane mask (SB: `4'b0001 << addr[1:0]`; SH: `4'b0011 << addr[1:0]`) and `req_wdata` replicated across lanes.
  - Latency is 2, same as SW.
- Undefined (default):
  - Read-modify-write as above.
  - `mem_we` is only ever `4'h0` or `4'hF`.

## Test plan
- SW `0x10` ← `0xDEADBEEF`:
  - WR in cycle 1 with `mem_addr=4`, `mem_we=F`; `resp_valid` in cycle 2.
  - LW `0x10` then returns `0xDEADBEEF` in cycle 3.
- SB `0x11` ← `0xAA`:
  - Word 4 becomes `0xDEADAAEF`; `resp_valid` in cycle 4 (default build) or cycle 2 (`MEM_LSU_NATIVE_BE_EN`).
  - LB `0x11` → `0xFFFFFFAA`; LBU `0x11` → `0x000000AA`.
- SH `0x12` ← `0x8034`:
  - Word 4 becomes `0x8034AAEF`.
  - LH `0x12` → `0xFFFF8034`; LHU → `0x00008034`.
- LW `0x13`, SH `0x11`, and funct3 `011`:
  - Each gives `resp_err=1` in cycle 1 and `mem_we` stays 0.
  - A subsequent LW `0x10` confirms memory is unchanged.
- `reset` asserted during DATA of SB `0x10`:
  - No write to word 4; no `resp_valid`.
  - `req_ready=1` in the first cycle after `reset` deasserts.
- Back-to-back:
  - LW accepted in the `resp_valid` cycle of a prior SW returns the newly written data.
  - SW `0x800` with `SIZE=512` aliases word 0.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store initiator for a single-port word RAM: extends loads, does sub-word stores as read-modify-write.
// Optional build macro MEM_LSU_NATIVE_BE_EN: RAM honours byte enables, so SB/SH write directly.
module mem_lsu #(
  parameter int SIZE = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata
);

  // state | meaning
  // IDLE  | ready for a request; error responses are issued from here
  // RD    | word address presented to the RAM for a read
  // DATA  | RAM read data valid; finish a load or merge a sub-word store
  // WR    | full-word (or lane-masked) write to the RAM, then respond
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] WR   = 2'd3;

  if (SIZE < 1) begin : g_size_chk
    $error("mem_lsu: SIZE must be positive");
  end

  logic [1:0]  state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wd_q;
  logic        accept;
  logic        req_illegal;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ld_val;
  logic [31:0] st_merge;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_illegal = 1'b1;
    case (req_funct3)
      3'b000:  req_illegal = 1'b0;
      3'b001:  req_illegal = req_addr[0];
      3'b010:  req_illegal = (req_addr[1:0] != 2'b00);
      3'b100:  req_illegal = req_we;
      3'b101:  req_illegal = req_we | req_addr[0];
      default: req_illegal = 1'b1;
    endcase
  end

  // Lane extraction and merge both work on the word read back in DATA.
  always_comb begin
    rbyte    = mem_rdata[{lane_q, 3'b000} +: 8];
    rhalf    = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_val   = mem_rdata;
    st_merge = mem_rdata;
    case (f3_q[1:0])
      2'b00: begin
        ld_val = f3_q[2] ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
        st_merge[{lane_q, 3'b000} +: 8] = wd_q[7:0];
      end
      2'b01: begin
        ld_val = f3_q[2] ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
        st_merge[{lane_q[1], 4'b0000} +: 16] = wd_q;
      end
      default: begin
        ld_val   = mem_rdata;
        st_merge = mem_rdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_we     <= 4'h0;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      lane_q     <= 2'b00;
      wd_q       <= 16'h0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      mem_we     <= 4'h0;
      case (state)
        IDLE: begin
          if (accept) begin
            we_q     <= req_we;
            f3_q     <= req_funct3;
            lane_q   <= req_addr[1:0];
            wd_q     <= req_wdata[15:0];
            mem_addr <= {2'b00, req_addr[31:2]};
            if (req_illegal) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
              mem_wdata <= req_wdata;
              mem_we    <= 4'hF;
              state     <= WR;
            end
`ifdef MEM_LSU_NATIVE_BE_EN
            else if (req_we) begin
              // Replicate the store data so every lane carries it; the mask picks the target.
              if (req_funct3[1:0] == 2'b00) begin
                mem_wdata <= {4{req_wdata[7:0]}};
                mem_we    <= 4'b0001 << req_addr[1:0];
              end else begin
                mem_wdata <= {2{req_wdata[15:0]}};
                mem_we    <= 4'b0011 << req_addr[1:0];
              end
              state <= WR;
            end
`endif
            else begin
              state <= RD;
            end
          end
        end
        RD: state <= DATA;
        DATA: begin
          if (we_q) begin
            mem_wdata <= st_merge;
            mem_we    <= 4'hF;
            state     <= WR;
          end else begin
            resp_rdata <= ld_val;
            resp_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        WR: begin
          resp_rdata <= 32'h0;
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: a synchronous-read RAM model plus a byte-array reference model.
// Directed cases first, then randomized loads/stores with aliased addresses.
module tb_mem_lsu;
  localparam int SIZE  = 512;
  localparam int BYTES = SIZE * 4;
  localparam int AW    = $clog2(SIZE);
`ifdef MEM_LSU_NATIVE_BE_EN
  localparam bit NATIVE = 1'b1;
`else
  localparam bit NATIVE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_lsu #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // RAM: index truncated to its depth, byte enables honoured, registered read.
  logic [31:0]   ram [0:SIZE-1];
  logic [31:0]   ram_q;
  logic [AW-1:0] ridx;
  assign ridx      = mem_addr[AW-1:0];
  assign mem_rdata = ram_q;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we[i]) ram[ridx][8*i +: 8] <= mem_wdata[8*i +: 8];
    ram_q <= ram[ridx];
  end

  bit [7:0] refm [0:BYTES-1];
  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit m_err(input bit we, input bit [2:0] f3, input bit [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (we && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_n(input bit [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic int m_idx(input bit [31:0] a);
    return int'(a % BYTES);
  endfunction

  function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a);
    longint v = 0;
    int n = m_n(f3);
    for (int i = 0; i < n; i++) v += longint'(refm[m_idx(a + i)]) << (8 * i);
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic bit [31:0] m_word(input bit [31:0] a);
    bit [31:0] base = a & ~32'h3;
    return m_load(3'b010, base);
  endfunction

  task automatic m_store(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
    for (int i = 0; i < m_n(f3); i++) refm[m_idx(a + i)] = 8'(wd >> (8 * i));
  endtask

  // Issue one request at a negedge (possibly the resp_valid negedge of the previous one)
  // and return at the negedge where resp_valid is seen.
  task automatic xact(input bit we, input bit [2:0] f3, input bit [31:0] a,
                      input bit [31:0] wd, output logic [31:0] rd);
    bit          err;
    int          n, lat, got_lat, nwe, we_at;
    logic [3:0]  we_seen, exp_we;
    logic [31:0] exp_rd, exp_word, addr_seen, wdata_seen;
    err      = m_err(we, f3, a);
    n        = m_n(f3);
    exp_rd   = (err || we) ? 32'h0 : m_load(f3, a);
    lat      = err ? 1 : !we ? 3 : (n == 4 || NATIVE) ? 2 : 4;
    exp_we   = (NATIVE && n < 4) ? (((n == 1) ? 4'b0001 : 4'b0011) << a[1:0]) : 4'hF;
    exp_word = 32'h0;
    if (!err && we) begin
      m_store(f3, a, wd);
      exp_word = m_word(a);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    chk("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    got_lat = 0; nwe = 0; we_at = 0;
    we_seen = 4'h0; addr_seen = 32'h0; wdata_seen = 32'h0;
    for (int k = 1; k <= 8 && got_lat == 0; k++) begin
      if (mem_we != 4'h0) begin
        nwe++; we_at = k; we_seen = mem_we; addr_seen = mem_addr; wdata_seen = mem_wdata;
      end
      if (resp_valid) got_lat = k;
      else begin @(posedge clk); @(negedge clk); end
    end
    chk("latency", 32'(got_lat), 32'(lat));
    chk("resp_err", 32'(resp_err), 32'(err));
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("write_count", 32'(nwe), (we && !err) ? 32'd1 : 32'd0);
    if (we && !err) begin
      chk("write_cycle", 32'(we_at), 32'(lat - 1));
      chk("mem_we", 32'(we_seen), 32'(exp_we));
      chk("mem_addr", addr_seen, a >> 2);
      if (!NATIVE || n == 4) chk("mem_wdata", wdata_seen, exp_word);
    end
    rd = resp_rdata;
  endtask

  initial begin
    logic [31:0] rd, x;
    bit [2:0]    f3;
    bit [31:0]   a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);

    for (int w = 0; w < 16; w++) xact(1'b1, 3'b010, 32'(w * 4), $urandom, rd);

    xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd);        chk("lw_10", rd, 32'hDEADBEEF);
    xact(1'b1, 3'b000, 32'h11, 32'h000000AA, rd);
    xact(1'b0, 3'b000, 32'h11, 32'h0, rd);        chk("lb_11", rd, 32'hFFFFFFAA);
    xact(1'b0, 3'b100, 32'h11, 32'h0, rd);        chk("lbu_11", rd, 32'h000000AA);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd);        chk("lw_after_sb", rd, 32'hDEADAAEF);
    xact(1'b1, 3'b001, 32'h12, 32'h00008034, rd);
    xact(1'b0, 3'b001, 32'h12, 32'h0, rd);        chk("lh_12", rd, 32'hFFFF8034);
    xact(1'b0, 3'b101, 32'h12, 32'h0, rd);        chk("lhu_12", rd, 32'h00008034);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd);        chk("lw_after_sh", rd, 32'h8034AAEF);

    xact(1'b0, 3'b010, 32'h13, 32'h0, rd);
    xact(1'b1, 3'b001, 32'h11, 32'h5555, rd);
    xact(1'b0, 3'b011, 32'h10, 32'h0, rd);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd);        chk("lw_after_err", rd, 32'h8034AAEF);

    // Reset lands on the DATA cycle of an SB; nothing may be written or answered.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstmid_mem_we", 32'(mem_we), 32'd0);
    chk("rstmid_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    if (NATIVE) m_store(3'b000, 32'h10, 32'h55);
    @(posedge clk); @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd);
    chk("lw_after_rst", rd, m_word(32'h10));

    x = $urandom;
    xact(1'b1, 3'b010, 32'h20, x, rd);
    xact(1'b0, 3'b010, 32'h20, 32'h0, rd);        chk("b2b_lw", rd, x);
    xact(1'b1, 3'b010, 32'h800, 32'h12345678, rd);
    xact(1'b0, 3'b010, 32'h0, 32'h0, rd);         chk("alias_lw_0", rd, 32'h12345678);

    for (int t = 0; t < 200; t++) begin
      f3 = 3'($urandom);
      a  = ($urandom & ~32'h7FF) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); @(negedge clk);
      end
      xact(1'($urandom), f3, a, $urandom, rd);
    end

    for (int w = 0; w < 16; w++) chk("ram_word", ram[w], m_word(32'(w * 4)));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
